pipeline_hazard_controller: RTL

//  Sequences the 3-stage pipeline (fetch | decode-execute | memory-writeback). Generates stall, flush and

---
 rtl/pipeline_hazard_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing control for the 3-stage pipeline: stall/flush/bubble,
// operand forwarding selects and the data-memory handshake with timeout.
module pipeline_hazard_controller #(
    parameter bit LOAD_FWD = 1'b0,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic             use_rs1_de,
    input  logic             use_rs2_de,
    input  logic             br_taken_de,
    input  logic [4:0]       rd_mw,
    input  logic             reg_wr_mw,
    input  logic             is_load_mw,
    input  logic             mem_access_mw,
    input  logic             mem_ready,
    output logic             stall_f,
    output logic             stall_de,
    output logic             flush_fd,
    output logic             bubble_mw,
    output logic             br_take,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_valid,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count
);
    // state    | meaning
    // RUN      | normal issue; forwarding and branch redirect active
    // MEM_WAIT | data access outstanding; pipeline frozen, MW held
    // LU_STALL | single cycle after a load-use bubble; operands from regfile
    // HALT     | access timed out; frozen until reset
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] LU_STALL = 2'd2;
    localparam logic [1:0] HALT     = 2'd3;

    localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       hit_a, hit_b, lu_hit, last_wait;
    logic       s_stall, s_bubble, s_br, s_valid;
    logic [1:0] s_fwd_a, s_fwd_b;

    assign hit_a  = use_rs1_de & reg_wr_mw & (rd_mw != 5'd0) & (rd_mw == rs1_de);
    assign hit_b  = use_rs2_de & reg_wr_mw & (rd_mw != 5'd0) & (rd_mw == rs2_de);
    assign lu_hit = (hit_a | hit_b) & is_load_mw & ~LOAD_FWD;

    // wait_q holds the not-ready cycles still allowed; the first one is spent in RUN
    assign last_wait = (state_q == RUN) ? (TIMEOUT <= 1) : (wait_q <= 8'd1);

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        err_d    = err_q;
        s_stall  = 1'b0;
        s_bubble = 1'b0;
        s_br     = 1'b0;
        s_valid  = 1'b0;
        s_fwd_a  = 2'b00;
        s_fwd_b  = 2'b00;
        case (state_q)
            RUN, MEM_WAIT: begin
                s_valid = (state_q == MEM_WAIT) | mem_access_mw;
                if (s_valid & ~mem_ready) begin
                    s_stall = 1'b1;
                    if (last_wait) begin
                        state_d = HALT;
                        err_d   = 1'b1;
                        wait_d  = 8'd0;
                    end else begin
                        state_d = MEM_WAIT;
                        wait_d  = (state_q == RUN) ? WAIT_LOAD : wait_q - 8'd1;
                    end
                end else begin
                    // access done (or none): the cycle resolves exactly like RUN
                    wait_d = 8'd0;
                    if (lu_hit) begin
                        s_stall  = 1'b1;
                        s_bubble = 1'b1;
                        state_d  = LU_STALL;
                    end else begin
                        state_d = RUN;
                        s_fwd_a = hit_a ? (is_load_mw ? 2'b10 : 2'b01) : 2'b00;
                        s_fwd_b = hit_b ? (is_load_mw ? 2'b10 : 2'b01) : 2'b00;
                        s_br    = br_taken_de;
                    end
                end
            end
            LU_STALL: begin
                state_d = RUN;
                s_br    = br_taken_de;
            end
            default: begin
                s_stall  = 1'b1;
                s_bubble = 1'b1;
                err_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (s_stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_q      <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // gate with reset so every output is 0 while reset is held
    assign stall_f     = reset & s_stall;
    assign stall_de    = reset & s_stall;
    assign bubble_mw   = reset & s_bubble;
    assign br_take     = reset & s_br;
    assign flush_fd    = reset & s_br;
    assign mem_valid   = reset & s_valid;
    assign fwd_a       = reset ? s_fwd_a : 2'b00;
    assign fwd_b       = reset ? s_fwd_b : 2'b00;
    assign mem_error   = err_q;
    assign stall_count = stall_cnt_q;

endmodule
